// File: rtl/snn_input_loader.sv
// snn_input_loader: takes a 28x28 binary image as 98 UART bytes and unpacks them
// one pixel per cycle into a 1-bit input-unit RAM. It pulses start when the image
// is complete and serves snn_core's reads until core_done, then waits for the next image.
//
//  state     | meaning
//  ----------+--------------------------------------------------------------
//  LOAD      | idle, waiting for the next byte from the UART receiver
//  UNPACK    | writing the 8 pixels of the captured byte, one per cycle
//  START     | image complete; start is high for this single cycle
//  WAIT_CORE | RAM is stable for snn_core; waiting for core_done
module snn_input_loader #(
    parameter int NUM_BYTES = 98,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    input  logic [ADDR_W-1:0] addr_input_unit,
    output logic              q_input,
    output logic              start,
    input  logic              core_done,
    output logic              busy,
    output logic              overrun
);

    localparam int BYTE_W = $clog2(NUM_BYTES);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        LOAD      = 2'd0,
        UNPACK    = 2'd1,
        START     = 2'd2,
        WAIT_CORE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [BYTE_W-1:0] byte_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift_reg;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              mem [0:(2**ADDR_W)-1];

    // Pixel index is byte_cnt*8 + bit_cnt, i.e. a plain concatenation.
    assign wr_addr = ADDR_W'({byte_cnt, bit_cnt});

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        busy       = 1'b1;
        wr_en      = 1'b0;
        case (state)
            LOAD: begin
                busy = 1'b0;
                if (rx_rdy) begin
                    state_next = UNPACK;
                end
            end
            UNPACK: begin
                wr_en = 1'b1;
                if (bit_cnt == 3'd7) begin
                    state_next = (byte_cnt == LAST_BYTE) ? START : LOAD;
                end
            end
            START: begin
                start      = 1'b1;
                state_next = WAIT_CORE;
            end
            WAIT_CORE: begin
                if (core_done) begin
                    state_next = LOAD;
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    // Byte capture, pixel/byte counters and the sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            overrun   <= 1'b0;
        end else begin
            if (rx_rdy && (state != LOAD)) begin
                overrun <= 1'b1;
            end
            case (state)
                LOAD: begin
                    if (rx_rdy) begin
                        shift_reg <= rx_data;
                        bit_cnt   <= '0;
                    end
                end
                UNPACK: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        byte_cnt <= (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // RAM write port; contents are not reset since every image rewrites all pixels.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= shift_reg[bit_cnt];
        end
    end

    // Registered read port; a same-address write in this cycle returns the old bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_input <= 1'b0;
        end else begin
            q_input <= mem[addr_input_unit];
        end
    end

endmodule
